// File: rtl/pixel_replication_2x.sv
// 2x nearest-neighbour upscaler: each source pixel is read once from synchronous RAM
// and written as a 2x2 block into a frame buffer twice as wide and twice as tall.
module pixel_replication_2x #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  pixel_in,
    output logic [14:0] read_addr,
    output logic [16:0] write_addr,
    output logic [7:0]  pixel_out,
    output logic        write_en,
    output logic        busy,
    output logic        done
);

    localparam int OUT_W = 2 * IMG_WIDTH_IN;
    localparam int XW    = (IMG_WIDTH_IN  > 1) ? $clog2(IMG_WIDTH_IN)  : 1;
    localparam int YW    = (IMG_HEIGHT_IN > 1) ? $clog2(IMG_HEIGHT_IN) : 1;

    localparam logic [XW-1:0] X_LAST     = XW'(IMG_WIDTH_IN - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(IMG_HEIGHT_IN - 1);
    localparam logic [16:0]   STEP_PIXEL = 17'd2;
    // End of a source row also skips the odd output line that the BL/BR writes filled.
    localparam logic [16:0]   STEP_ROW   = 17'(OUT_W + 2);
    localparam logic [16:0]   OFF_BL     = 17'(OUT_W);
    localparam logic [16:0]   OFF_BR     = 17'(OUT_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t        state_reg;
    logic [XW-1:0] x_reg;
    logic [YW-1:0] y_reg;
    logic [1:0]    sub_reg;
    logic [16:0]   base_reg;
    logic [14:0]   read_addr_reg;
    logic [16:0]   write_addr_reg;
    logic [7:0]    pixel_out_reg;
    logic          write_en_reg;
    logic          busy_reg;
    logic          done_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            sub_reg        <= '0;
            base_reg       <= '0;
            read_addr_reg  <= '0;
            write_addr_reg <= '0;
            pixel_out_reg  <= '0;
            write_en_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        x_reg         <= '0;
                        y_reg         <= '0;
                        sub_reg       <= '0;
                        base_reg      <= '0;
                        read_addr_reg <= '0;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        state_reg     <= ST_READ;
                    end
                end
                ST_READ: begin
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // RAM data for read_addr is valid now; first write is the top-left.
                    pixel_out_reg  <= pixel_in;
                    write_en_reg   <= 1'b1;
                    write_addr_reg <= base_reg;
                    sub_reg        <= '0;
                    state_reg      <= ST_WRITE;
                end
                ST_WRITE: begin
                    sub_reg <= sub_reg + 2'd1;
                    case (sub_reg)
                        2'd0: write_addr_reg <= base_reg + 17'd1;
                        2'd1: write_addr_reg <= base_reg + OFF_BL;
                        2'd2: write_addr_reg <= base_reg + OFF_BR;
                        default: begin
                            write_en_reg <= 1'b0;
                            if (x_reg == X_LAST && y_reg == Y_LAST) begin
                                busy_reg  <= 1'b0;
                                done_reg  <= 1'b1;
                                state_reg <= ST_DONE;
                            end else begin
                                read_addr_reg <= read_addr_reg + 15'd1;
                                state_reg     <= ST_READ;
                                if (x_reg == X_LAST) begin
                                    x_reg    <= '0;
                                    y_reg    <= y_reg + YW'(1);
                                    base_reg <= base_reg + STEP_ROW;
                                end else begin
                                    x_reg    <= x_reg + XW'(1);
                                    base_reg <= base_reg + STEP_PIXEL;
                                end
                            end
                        end
                    endcase
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign read_addr  = read_addr_reg;
    assign write_addr = write_addr_reg;
    assign pixel_out  = pixel_out_reg;
    assign write_en   = write_en_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_pixel_replication_2x.sv
// Bench for pixel_replication_2x on a 160x4 source: queue model of the expected write
// stream, literal pins on key blocks, done timing, mid-frame start and reset cases.
module tb_pixel_replication_2x;

    localparam int TW        = 160;
    localparam int TH        = 4;
    localparam int NPIX      = TW * TH;
    localparam int NOUT      = 4 * NPIX;
    localparam int OW        = 2 * TW;
    localparam int FRAME_CYC = 6 * NPIX;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  pixel_in;
    logic [14:0] read_addr;
    logic [16:0] write_addr;
    logic [7:0]  pixel_out;
    logic        write_en;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    pixel_replication_2x #(
        .IMG_WIDTH_IN (TW),
        .IMG_HEIGHT_IN(TH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pixel_in  (pixel_in),
        .read_addr (read_addr),
        .write_addr(write_addr),
        .pixel_out (pixel_out),
        .write_en  (write_en),
        .busy      (busy),
        .done      (done)
    );

    // Synchronous source RAM: registers the address, data valid the following cycle.
    logic [7:0] mem [NPIX];
    always @(posedge clk) begin
        pixel_in <= (int'(read_addr) < NPIX) ? mem[read_addr] : 8'h00;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [16:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [16:0] log_addr [NOUT];
    logic [7:0]  log_data [NOUT];
    int          wr_idx = 0;

    // Hand-computed write positions/values for the first, row-end, row-start and last blocks.
    int pin_idx  [16] = '{0, 1, 2, 3, 636, 637, 638, 639, 640, 641, 642, 643, 2556, 2557, 2558, 2559};
    int pin_addr [16] = '{0, 1, 320, 321, 318, 319, 638, 639, 640, 641, 960, 961, 2238, 2239, 2558, 2559};
    int pin_data [16] = '{'h5A, 'h5A, 'h5A, 'h5A, 'h33, 'h33, 'h33, 'h33,
                          'hA0, 'hA0, 'hA0, 'hA0, 'hC4, 'hC4, 'hC4, 'hC4};

    // Model: every source pixel becomes its 2x2 block, row-major, TL TR BL BR.
    task automatic load_model();
        wr_t e;
        exp_q.delete();
        for (int y = 0; y < TH; y++) begin
            for (int x = 0; x < TW; x++) begin
                for (int s = 0; s < 4; s++) begin
                    e.addr = 17'((2 * y + s / 2) * OW + 2 * x + s % 2);
                    e.data = mem[y * TW + x];
                    exp_q.push_back(e);
                end
            end
        end
        check("model_addr_3", int'(exp_q[3].addr), 321);
        check("model_addr_last", int'(exp_q[NOUT-1].addr), NOUT - 1);
        check("model_data_639", int'(exp_q[639].data), 'h33);
    endtask

    always @(negedge clk) begin
        if (write_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: write_addr 0x%0h data 0x%0h with none expected",
                         write_addr, pixel_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", int'(write_addr), int'(mon_e.addr));
                check("wr_data", int'(pixel_out), int'(mon_e.data));
            end
            if (wr_idx < NOUT) begin
                log_addr[wr_idx] = write_addr;
                log_data[wr_idx] = pixel_out;
            end
            wr_idx++;
        end
    end

    task automatic run_frame(input bit pulses);
        int n;
        bit got;
        int uniq;
        bit seen [NOUT];
        load_model();
        wr_idx = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_done", done, 0);
        check("first_read_addr", read_addr, 0);
        n = 0;
        got = 0;
        while (!got && n < FRAME_CYC + 100) begin
            @(posedge clk);
            n++;
            #1;
            if (done) begin
                got = 1;
            end else begin
                if (n == 6) check("second_read_addr", read_addr, 1);
                start = pulses && (n == 10 || n == 500 || n == 3000);
            end
        end
        start = 1'b0;
        check("done_edge", n, FRAME_CYC);
        check("end_busy", busy, 0);
        check("end_write_en", write_en, 0);
        check("model_drained", exp_q.size(), 0);
        check("write_count", wr_idx, NOUT);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("pin_addr_%0d", pin_idx[i]), int'(log_addr[pin_idx[i]]), pin_addr[i]);
            check($sformatf("pin_data_%0d", pin_idx[i]), int'(log_data[pin_idx[i]]), pin_data[i]);
        end
        uniq = 0;
        for (int i = 0; i < NOUT; i++) seen[i] = 1'b0;
        for (int i = 0; i < NOUT; i++) begin
            if (int'(log_addr[i]) < NOUT && !seen[log_addr[i]]) begin
                seen[log_addr[i]] = 1'b1;
                uniq++;
            end
        end
        check("unique_addrs", uniq, NOUT);
    endtask

    initial begin
        int n;
        int bad;
        bit found;
        reset_n = 1'b0;
        start   = 1'b0;
        for (int a = 0; a < NPIX; a++) mem[a] = 8'(a);
        mem[0]       = 8'h5A;
        mem[TW-1]    = 8'h33;
        mem[NPIX-1]  = 8'hC4;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read_addr", read_addr, 0);
        check("rst_write_addr", write_addr, 0);
        check("rst_pixel_out", pixel_out, 0);
        check("rst_write_en", write_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Frame with stray start pulses mid-frame.
        run_frame(1'b1);
        $display("frame 1 complete, writes %0d", wr_idx);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!(done === 1'b1 && busy === 1'b0 && write_en === 1'b0)) bad++;
        end
        check("done_hold_bad_cycles", bad, 0);

        // Restart from DONE: identical frame expected.
        run_frame(1'b0);
        $display("frame 2 complete, writes %0d", wr_idx);

        // Reset during the BL write of source pixel (5,0).
        load_model();
        wr_idx = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        found = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (write_en && write_addr == 17'd330) found = 1;
        end
        check("reached_sub2", found, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_write_en", write_en, 0);
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_read_addr", read_addr, 0);
        check("async_write_addr", write_addr, 0);
        check("async_pixel_out", pixel_out, 0);
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            check("in_reset_write_en", write_en, 0);
        end
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_done", done, 0);
        $display("reset mid-frame applied after %0d cycles", n);

        run_frame(1'b0);
        $display("frame 3 complete, writes %0d", wr_idx);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
